// File: rtl/wrr_arb.sv
// Weighted round-robin arbiter: per-requester credits refilled from weights, packet locking
// until the final beat, and a combinational grant from requests and state.
module wrr_arb #(
    parameter int unsigned  W        = 4,
    parameter int unsigned  WEIGHT_W = 4,
    localparam int unsigned PTR_W    = (W > 1) ? $clog2(W) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          i_req,
    input  logic [W*WEIGHT_W-1:0] i_weight,
    input  logic                  i_ack,
    input  logic                  i_last,
    output logic [W-1:0]          o_gnt,
    output logic [PTR_W-1:0]      o_gnt_enc,
    output logic                  o_gnt_vld
);

    typedef enum logic {StUnlocked, StLocked} lock_e;

    lock_e               lock_r, lock_d;
    logic [PTR_W-1:0]    ptr_r, ptr_d;
    logic [PTR_W-1:0]    lock_idx_r, lock_idx_d;
    logic [WEIGHT_W-1:0] cred_r [W];
    logic [WEIGHT_W-1:0] cred_d [W];
    logic [WEIGHT_W-1:0] eff_wt [W];

    logic [W-1:0]        has_cred, elig, elig_rot, win_oh, lock_oh;
    logic                replenish, found, beat;
    logic [PTR_W-1:0]    win_idx, cur_idx, nxt_idx;
    logic [WEIGHT_W-1:0] base, cur_post;

    // A zero weight still buys one packet per round.
    always_comb begin : eff_weights
        for (int i = 0; i < W; i++) begin
            eff_wt[i] = i_weight[i*WEIGHT_W +: WEIGHT_W];
            if (eff_wt[i] == '0) begin
                eff_wt[i] = WEIGHT_W'(1);
            end
        end
    end

    always_comb begin : eligibility
        for (int i = 0; i < W; i++) begin
            has_cred[i] = i_req[i] && (cred_r[i] != '0);
        end
        replenish = (has_cred == '0) && (i_req != '0);
        elig      = replenish ? i_req : has_cred;
        // Rotate so bit 0 corresponds to ptr_r; the doubled vector handles the wrap.
        elig_rot  = W'({elig, elig} >> ptr_r);
    end

    always_comb begin : search
        found   = 1'b0;
        win_idx = '0;
        for (int unsigned k = 0; k < W; k++) begin
            if (!found && elig_rot[k]) begin
                found   = 1'b1;
                win_idx = (32'(ptr_r) + k >= W) ? PTR_W'(32'(ptr_r) + k - W)
                                                : PTR_W'(32'(ptr_r) + k);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_r     <= StUnlocked;
            lock_idx_r <= '0;
            ptr_r      <= '0;
            for (int i = 0; i < W; i++) begin
                cred_r[i] <= '0;
            end
        end else begin
            lock_r     <= lock_d;
            lock_idx_r <= lock_idx_d;
            ptr_r      <= ptr_d;
            for (int i = 0; i < W; i++) begin
                cred_r[i] <= cred_d[i];
            end
        end
    end

    // Next state
    always_comb begin : next_state
        beat       = i_ack && o_gnt_vld;
        cur_idx    = (lock_r == StLocked) ? lock_idx_r : win_idx;
        nxt_idx    = (32'(cur_idx) + 32'd1 >= W) ? '0 : cur_idx + 1'b1;
        lock_d     = lock_r;
        lock_idx_d = lock_idx_r;
        ptr_d      = ptr_r;
        cur_post   = '0;
        base       = '0;

        // Only the first beat of a packet spends credit; locked beats leave it alone.
        for (int i = 0; i < W; i++) begin
            base = (lock_r == StUnlocked && replenish) ? eff_wt[i] : cred_r[i];
            if (cur_idx == PTR_W'(i)) begin
                if (lock_r == StUnlocked && base != '0) begin
                    base = base - 1'b1;
                end
                cur_post = base;
            end
            cred_d[i] = (beat && lock_r == StUnlocked) ? base : cred_r[i];
        end

        if (beat) begin
            unique case (lock_r)
                StUnlocked: begin
                    if (!i_last) begin
                        lock_d     = StLocked;
                        lock_idx_d = win_idx;
                    end
                end
                StLocked: begin
                    if (i_last) begin
                        lock_d = StUnlocked;
                    end
                end
            endcase
            // Stay on the winner while it still has credit so it repeats up to its weight.
            if (i_last) begin
                ptr_d = (cur_post == '0) ? nxt_idx : cur_idx;
            end
        end
    end

    // Outputs
    always_comb begin : outputs
        for (int i = 0; i < W; i++) begin
            win_oh[i]  = found && (win_idx == PTR_W'(i));
            lock_oh[i] = (lock_idx_r == PTR_W'(i));
        end
        o_gnt = '0;
        unique case (lock_r)
            StUnlocked: o_gnt = win_oh;
            StLocked:   o_gnt = lock_oh & i_req;
        endcase
        o_gnt_vld = |o_gnt;
        o_gnt_enc = '0;
        for (int i = 0; i < W; i++) begin
            if (o_gnt[i]) begin
                o_gnt_enc = o_gnt_enc | PTR_W'(i);
            end
        end
    end

endmodule

// File: tb/tb_wrr_arb.sv
// Directed bench for wrr_arb: W=4 vector table plus short W=3 and W=1 sequences.
module tb_wrr_arb;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] wt;
        logic        ack;
        logic        last;
        logic        chk;
        logic [3:0]  gnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] wt;
    logic        ack, last;
    logic [3:0]  gnt;
    logic [1:0]  enc;
    logic        vld;

    logic [2:0]  req3;
    logic [11:0] wt3;
    logic [2:0]  gnt3;
    logic [1:0]  enc3;
    logic        vld3;

    logic        req1;
    logic [3:0]  wt1;
    logic        gnt1;
    logic        enc1;
    logic        vld1;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    wrr_arb #(.W(4), .WEIGHT_W(4)) u_dut (
        .clk(clk), .rst(rst), .i_req(req), .i_weight(wt), .i_ack(ack), .i_last(last),
        .o_gnt(gnt), .o_gnt_enc(enc), .o_gnt_vld(vld)
    );

    wrr_arb #(.W(3), .WEIGHT_W(4)) u_dut3 (
        .clk(clk), .rst(rst), .i_req(req3), .i_weight(wt3), .i_ack(ack), .i_last(last),
        .o_gnt(gnt3), .o_gnt_enc(enc3), .o_gnt_vld(vld3)
    );

    wrr_arb #(.W(1), .WEIGHT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .i_req(req1), .i_weight(wt1), .i_ack(ack), .i_last(last),
        .o_gnt(gnt1), .o_gnt_enc(enc1), .o_gnt_vld(vld1)
    );

    function automatic logic [1:0] enc_of(input logic [3:0] g);
        logic [1:0] e;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) e = 2'(i);
        end
        return e;
    endfunction

    function automatic void add(input logic r, input logic [3:0] rq, input logic [15:0] w,
                                input logic a, input logic l, input logic c,
                                input logic [3:0] g);
        vec_t v;
        v.rst  = r;
        v.req  = rq;
        v.wt   = w;
        v.ack  = a;
        v.last = l;
        v.chk  = c;
        v.gnt  = g;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h exp=%0h", nm, idx, got, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int exp3 [5];
        logic [2:0] eg;
        exp3 = '{0, 1, 2, 0, 1};

        rst  = 1'b1;
        req  = '0;
        wt   = 16'h1111;
        ack  = 1'b0;
        last = 1'b0;
        req3 = '0;
        wt3  = 12'h111;
        req1 = 1'b0;
        wt1  = 4'h0;

        // Reset, idle outputs, and an ack with nothing granted.
        add(1, 4'h0, 16'h1111, 0, 0, 0, 4'h0);
        add(0, 4'h0, 16'h1111, 0, 0, 1, 4'h0);
        add(0, 4'h0, 16'h1111, 1, 1, 1, 4'h0);
        // Equal weights, all requesting: 0,1,2,3,0,1.
        add(0, 4'hF, 16'h1111, 1, 1, 1, 4'h1);
        add(0, 4'hF, 16'h1111, 1, 1, 1, 4'h2);
        add(0, 4'hF, 16'h1111, 1, 1, 1, 4'h4);
        add(0, 4'hF, 16'h1111, 1, 1, 1, 4'h8);
        add(0, 4'hF, 16'h1111, 1, 1, 1, 4'h1);
        add(0, 4'hF, 16'h1111, 1, 1, 1, 4'h2);
        // w0=3, w1=1: 0,0,0,1,0,0,0,1.
        add(1, 4'h0, 16'h1113, 0, 0, 0, 4'h0);
        add(0, 4'h3, 16'h1113, 1, 1, 1, 4'h1);
        add(0, 4'h3, 16'h1113, 1, 1, 1, 4'h1);
        add(0, 4'h3, 16'h1113, 1, 1, 1, 4'h1);
        add(0, 4'h3, 16'h1113, 1, 1, 1, 4'h2);
        add(0, 4'h3, 16'h1113, 1, 1, 1, 4'h1);
        add(0, 4'h3, 16'h1113, 1, 1, 1, 4'h1);
        add(0, 4'h3, 16'h1113, 1, 1, 1, 4'h1);
        add(0, 4'h3, 16'h1113, 1, 1, 1, 4'h2);
        // Three-beat packet on 0 (with a dropped request mid-lock), then 1.
        add(1, 4'h0, 16'h1111, 0, 0, 0, 4'h0);
        add(0, 4'h3, 16'h1111, 1, 0, 1, 4'h1);
        add(0, 4'h2, 16'h1111, 1, 1, 1, 4'h0);
        add(0, 4'h3, 16'h1111, 1, 0, 1, 4'h1);
        add(0, 4'h3, 16'h1111, 1, 1, 1, 4'h1);
        add(0, 4'h3, 16'h1111, 1, 1, 1, 4'h2);
        add(0, 4'h3, 16'h1111, 1, 1, 1, 4'h1);
        // w0=3: a three-beat packet costs one credit, leaving two more packets for 0.
        add(1, 4'h0, 16'h1113, 0, 0, 0, 4'h0);
        add(0, 4'h3, 16'h1113, 1, 0, 1, 4'h1);
        add(0, 4'h3, 16'h1113, 1, 0, 1, 4'h1);
        add(0, 4'h3, 16'h1113, 1, 1, 1, 4'h1);
        add(0, 4'h3, 16'h1113, 1, 1, 1, 4'h1);
        add(0, 4'h3, 16'h1113, 1, 1, 1, 4'h1);
        add(0, 4'h3, 16'h1113, 1, 1, 1, 4'h2);
        // Held grant without ack, then advance.
        add(1, 4'h0, 16'h1111, 0, 0, 0, 4'h0);
        for (int i = 0; i < 5; i++) add(0, 4'hA, 16'h1111, 0, 0, 1, 4'h2);
        add(0, 4'hA, 16'h1111, 1, 1, 1, 4'h2);
        add(0, 4'hA, 16'h1111, 0, 0, 1, 4'h8);
        add(0, 4'hA, 16'h1111, 0, 0, 1, 4'h8);
        // w3=0 behaves as 1, wrap 3 -> 0.
        add(1, 4'h0, 16'h0111, 0, 0, 0, 4'h0);
        add(0, 4'hF, 16'h0111, 1, 1, 1, 4'h1);
        add(0, 4'hF, 16'h0111, 1, 1, 1, 4'h2);
        add(0, 4'hF, 16'h0111, 1, 1, 1, 4'h4);
        add(0, 4'h9, 16'h0111, 1, 1, 1, 4'h8);
        add(0, 4'h9, 16'h0111, 1, 1, 1, 4'h1);
        add(0, 4'h9, 16'h0111, 1, 1, 1, 4'h8);
        // w1=0 still earns a turn within the round.
        add(1, 4'h0, 16'h1101, 0, 0, 0, 4'h0);
        add(0, 4'h7, 16'h1101, 1, 1, 1, 4'h1);
        add(0, 4'h7, 16'h1101, 1, 1, 1, 4'h2);
        add(0, 4'h7, 16'h1101, 1, 1, 1, 4'h4);
        add(0, 4'h7, 16'h1101, 1, 1, 1, 4'h1);
        // Reset mid-packet abandons the lock on 2.
        add(1, 4'h0, 16'h1111, 0, 0, 0, 4'h0);
        add(0, 4'h4, 16'h1111, 1, 0, 1, 4'h4);
        add(1, 4'h5, 16'h1111, 1, 1, 0, 4'h0);
        add(0, 4'h5, 16'h1111, 0, 0, 1, 4'h1);
        add(0, 4'h5, 16'h1111, 0, 0, 1, 4'h1);

        foreach (vecs[n]) begin
            rst  = vecs[n].rst;
            req  = vecs[n].req;
            wt   = vecs[n].wt;
            ack  = vecs[n].ack;
            last = vecs[n].last;
            #2;
            if (vecs[n].chk) begin
                check("vec", n, 32'({gnt, enc, vld}),
                      32'({vecs[n].gnt, enc_of(vecs[n].gnt), |vecs[n].gnt}));
            end
            @(posedge clk);
            #1;
        end

        // W=3: wrap from index 2 back to 0.
        req = '0;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            req3 = 3'b111;
            ack  = 1'b1;
            last = 1'b1;
            #2;
            eg = 3'b001 << exp3[i];
            check("w3", i, 32'({gnt3, enc3, vld3}), 32'({eg, 2'(exp3[i]), 1'b1}));
            @(posedge clk);
            #1;
        end
        req3 = '0;

        // W=1: single requester, zero weight, lock and drop.
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            req1 = 1'b1;
            ack  = 1'b1;
            last = 1'b1;
            #2;
            check("w1", i, 32'({gnt1, enc1, vld1}), 32'b101);
            @(posedge clk);
            #1;
        end
        last = 1'b0;
        #2;
        check("w1_lock", 0, 32'({gnt1, enc1, vld1}), 32'b101);
        @(posedge clk);
        #1;
        req1 = 1'b0;
        #2;
        check("w1_drop", 0, 32'({gnt1, enc1, vld1}), 32'b000);
        req1 = 1'b1;
        #2;
        check("w1_back", 0, 32'({gnt1, enc1, vld1}), 32'b101);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
